// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC.
// Returns atan2(y, x) in Q3.29 and the gain-scaled magnitude An*|v| in Q3.29.
// It performs one micro-rotation per clock on a shared datapath.
// The sequence for each vector is:
//   IDLE (capture) -> PRE (quadrant fold / zero detect) -> ITER x ITER -> DONE.
module cordic_vectoring #(
   parameter int ITER  = 16,   // micro-rotations, 8..30
   parameter int GUARD = 2     // headroom MSBs on x/y (magnitude grows by An*sqrt2)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x,
   input  logic [31:0] in_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_angle,
   output logic [31:0] out_mag,
   output logic        out_zero
);

   localparam int W = 32 + GUARD;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PRE  = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [4:0]  LAST_ITER   = 5'(ITER - 1);
   localparam logic [31:0] HALF_PI     = 32'h3243F6A8;
   localparam logic [31:0] NEG_HALF_PI = 32'hCDBC0958;

   logic [1:0]          state_q, state_d;
   logic signed [W-1:0] x_q, x_d;
   logic signed [W-1:0] y_q, y_d;
   logic [31:0]         z_q, z_d;
   logic [4:0]          iter_q, iter_d;
   logic [31:0]         angle_q, angle_d;
   logic [31:0]         mag_q, mag_d;
   logic                zero_q, zero_d;
   logic signed [W-1:0] x_shift, y_shift;

   // round(atan(2^-i) * 2^29); entries past i=29 are never addressed
   function automatic logic [31:0] atan_rom(input logic [4:0] idx);
      logic [31:0] v;
      case (idx)
         5'd0:  v = 32'h1921FB54;
         5'd1:  v = 32'h0ED63383;
         5'd2:  v = 32'h07D6DD7E;
         5'd3:  v = 32'h03FAB753;
         5'd4:  v = 32'h01FF55BB;
         5'd5:  v = 32'h00FFEAAE;
         5'd6:  v = 32'h007FFD55;
         5'd7:  v = 32'h003FFFAB;
         5'd8:  v = 32'h001FFFF5;
         5'd9:  v = 32'h000FFFFF;
         5'd10: v = 32'h00080000;
         5'd11: v = 32'h00040000;
         5'd12: v = 32'h00020000;
         5'd13: v = 32'h00010000;
         5'd14: v = 32'h00008000;
         5'd15: v = 32'h00004000;
         5'd16: v = 32'h00002000;
         5'd17: v = 32'h00001000;
         5'd18: v = 32'h00000800;
         5'd19: v = 32'h00000400;
         5'd20: v = 32'h00000200;
         5'd21: v = 32'h00000100;
         5'd22: v = 32'h00000080;
         5'd23: v = 32'h00000040;
         5'd24: v = 32'h00000020;
         5'd25: v = 32'h00000010;
         5'd26: v = 32'h00000008;
         5'd27: v = 32'h00000004;
         5'd28: v = 32'h00000002;
         5'd29: v = 32'h00000001;
         default: v = 32'h00000000;
      endcase
      return v;
   endfunction

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_angle = angle_q;
   assign out_mag   = mag_q;
   assign out_zero  = zero_q;

   // Next-state logic: capture, quadrant fold, micro-rotations, result hold
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      iter_d  = iter_q;
      angle_d = angle_q;
      mag_d   = mag_q;
      zero_d  = zero_q;
      x_shift = x_q >>> iter_q;
      y_shift = y_q >>> iter_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = {{GUARD{in_x[31]}}, in_x};
               y_d     = {{GUARD{in_y[31]}}, in_y};
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            z_d = 32'd0;
            if (x_q == '0 && y_q == '0) begin
               zero_d  = 1'b1;
               angle_d = 32'd0;
               mag_d   = 32'd0;
               state_d = S_DONE;
            end else begin
               zero_d  = 1'b0;
               iter_d  = 5'd0;
               state_d = S_ITER;
               // Fold left half-plane into the right so the iterations converge;
               // y = 0 with x < 0 takes the +pi/2 branch, giving +pi rather than -pi
               if (x_q[W-1] && !y_q[W-1]) begin
                  x_d = y_q;
                  y_d = -x_q;
                  z_d = HALF_PI;
               end else if (x_q[W-1]) begin
                  x_d = -y_q;
                  y_d = x_q;
                  z_d = NEG_HALF_PI;
               end
            end
         end
         S_ITER: begin
            // Drive y toward zero, accumulating the rotated angle in z
            if (!y_q[W-1]) begin
               x_d = x_q + y_shift;
               y_d = y_q - x_shift;
               z_d = z_q + atan_rom(iter_q);
            end else begin
               x_d = x_q - y_shift;
               y_d = y_q + x_shift;
               z_d = z_q - atan_rom(iter_q);
            end
            iter_d = iter_q + 5'd1;
            if (iter_q == LAST_ITER) begin
               angle_d = z_d;
               mag_d   = x_d[32:1];
               state_d = S_DONE;
            end
         end
         default: begin
            if (out_ready) state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight vector at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         angle_q <= '0;
         mag_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         iter_q  <= iter_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: hand-computed angles/magnitudes,
// latency, backpressure and asynchronous reset mid-iteration.
module tb_cordic_vectoring;

   localparam int ITER = 16;
   localparam longint MAG1  = 884097674;    // An * 1.0 * 2^29
   localparam longint MAGR2 = 1250302921;   // An * sqrt2 * 2^29
   localparam longint ATOL  = 65536;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = 32'd0;
   logic [31:0] in_y = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_angle;
   logic [31:0] out_mag;
   logic        out_zero;

   int n_cmp = 0;
   int n_bad = 0;

   cordic_vectoring #(.ITER(ITER), .GUARD(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_angle (out_angle),
      .out_mag   (out_mag),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   function automatic longint sa(input logic [31:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint ua(input logic [31:0] v);
      return longint'(v);
   endfunction

   task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
      longint d;
      n_cmp++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d +/- %0d", tag, obs, obs, exp, tol);
      end
   endtask

   // Send one vector, time the result, capture it, then pop it
   task automatic xfer(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, output logic [31:0] ang, output logic [31:0] mag,
                       output logic zer);
      int lat;
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      check_val({tag, ".in_ready"}, longint'(in_ready), 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, ".lat"}, lat, exp_lat, 0);
      ang = out_angle;
      mag = out_mag;
      zer = out_zero;
      $display("xfer %s x=%h y=%h -> angle=%h mag=%h zero=%0b lat=%0d", tag, x, y, ang, mag, zer, lat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ang, mag, a0, m0;
      logic        zer;
      int          cyc, stray;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst.out_valid", longint'(out_valid), 0, 0);
      check_val("rst.in_ready",  longint'(in_ready),  1, 0);
      check_val("rst.angle", ua(out_angle), 0, 0);
      check_val("rst.mag",   ua(out_mag),   0, 0);
      check_val("rst.zero",  longint'(out_zero), 0, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // (1, 0)
      xfer("x1y0", 32'h40000000, 32'h00000000, ITER + 2, ang, mag, zer);
      check_val("x1y0.angle", sa(ang), 0, ATOL);
      check_val("x1y0.mag",   ua(mag), MAG1, 131072);
      check_val("x1y0.zero",  longint'(zer), 0, 0);

      // (0, 1)
      xfer("x0y1", 32'h00000000, 32'h40000000, ITER + 2, ang, mag, zer);
      check_val("x0y1.angle", sa(ang), sa(32'h3243F6A8), ATOL);
      check_val("x0y1.mag",   ua(mag), MAG1, 131072);

      // (1, 1)
      xfer("x1y1", 32'h40000000, 32'h40000000, ITER + 2, ang, mag, zer);
      check_val("x1y1.angle", sa(ang), sa(32'h1921FB54), ATOL);
      check_val("x1y1.mag",   ua(mag), MAGR2, 262144);

      // (-1, 0) must land on +pi
      xfer("xm1y0", 32'hC0000000, 32'h00000000, ITER + 2, ang, mag, zer);
      check_val("xm1y0.angle", sa(ang), sa(32'h6487ED51), ATOL);
      check_val("xm1y0.mag",   ua(mag), MAG1, 131072);

      // (-1, -1 LSB) lands just above -pi
      xfer("xm1ym", 32'hC0000000, 32'hFFFFFFFF, ITER + 2, ang, mag, zer);
      check_val("xm1ym.angle", sa(ang), sa(32'h9B7812AF), ATOL);

      // (0.7071, -0.7071) -> -pi/4, unit magnitude
      xfer("q4", 32'h2D413CCD, 32'hD2BEC333, ITER + 2, ang, mag, zer);
      check_val("q4.angle", sa(ang), -sa(32'h1921FB54), ATOL);
      check_val("q4.mag",   ua(mag), MAG1, 131072);

      // zero vector short-cuts to DONE
      xfer("zero", 32'h00000000, 32'h00000000, 2, ang, mag, zer);
      check_val("zero.flag",  longint'(zer), 1, 0);
      check_val("zero.angle", ua(ang), 0, 0);
      check_val("zero.mag",   ua(mag), 0, 0);

      // out_zero clears on the next real vector
      xfer("after0", 32'h40000000, 32'h00000000, ITER + 2, ang, mag, zer);
      check_val("after0.zero", longint'(zer), 0, 0);

      // backpressure: hold result while a second vector is offered
      in_x = 32'h00000000;
      in_y = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val("bp.lat", cyc, ITER + 2, 0);
      a0 = out_angle;
      m0 = out_mag;
      check_val("bp.angle", sa(a0), sa(32'h3243F6A8), ATOL);
      in_x = 32'h40000000;
      in_y = 32'h40000000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_val("bp.out_valid", longint'(out_valid), 1, 0);
         check_val("bp.in_ready",  longint'(in_ready),  0, 0);
         check_val("bp.angle_hold", ua(out_angle), ua(a0), 0);
         check_val("bp.mag_hold",   ua(out_mag),   ua(m0), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("bp.release_valid", longint'(out_valid), 0, 0);
      check_val("bp.release_ready", longint'(in_ready),  1, 0);
      stray = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      check_val("bp.no_stray", stray, 0, 0);
      $display("xfer backpressure angle=%h mag=%h held 10 cycles", a0, m0);

      // asynchronous reset in the middle of the iterations
      in_x = 32'h40000000;
      in_y = 32'h00000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("mid.in_ready", longint'(in_ready), 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst2.out_valid", longint'(out_valid), 0, 0);
      check_val("rst2.in_ready",  longint'(in_ready),  1, 0);
      check_val("rst2.angle", ua(out_angle), 0, 0);
      check_val("rst2.mag",   ua(out_mag),   0, 0);
      check_val("rst2.zero",  longint'(out_zero), 0, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      $display("xfer reset pulsed mid-iteration");
      xfer("post_rst", 32'h40000000, 32'h40000000, ITER + 2, ang, mag, zer);
      check_val("post_rst.angle", sa(ang), sa(32'h1921FB54), ATOL);
      check_val("post_rst.mag",   ua(mag), MAGR2, 262144);
      check_val("post_rst.zero",  longint'(zer), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Iterative vectoring-mode CORDIC; the inverse direction of the team's rotation-mode trig calculator.
- Accepts a Cartesian vector (x, y) and returns its angle, atan2(y, x), and its gain-scaled magnitude.
- One micro-rotation per clock over a shared datapath, with valid/ready handshakes on both the input and output sides.
- Sits downstream of the rotation-mode unit, e.g. for recovering the angle of a computed (cos, sin) pair.

Parameters:
- ITER, 16, number of micro-rotations; legal range 8..30.
- GUARD, 2, extra MSBs on the internal x/y datapath.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_x/in_y valid.
- in_ready  output  1  block can accept a vector.
- in_x  input  32  x, two's-complement Q2.30 (1.0 = 0x40000000); |x| ≤ 1.0.
- in_y  input  32  y, same format and range as in_x.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_angle  output  32  atan2(y, x) in radians, two's-complement Q3.29, range (−π, +π].
- out_mag  output  32  An·sqrt(x²+y²), unsigned value in Q3.29 (An ≈ 1.646760258; not compensated).
- out_zero  output  1  input vector was (0, 0).

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_angle, out_mag, out_zero = 0; internal x/y/z/iteration counter = 0.
  - Takes effect immediately, including mid-iteration; any in-flight vector is discarded.
- FSM states: IDLE → PRE → ITER → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_x and in_y, go to PRE.
- PRE (1 cycle), quadrant pre-rotation (outputs sign-extended to 32+GUARD bits, Q(2+GUARD).30):
  - x ≥ 0: x' = x, y' = y, z = 0.
  - x < 0 and y ≥ 0: x' = y, y' = −x, z = +π/2 (0x3243F6A8).
  - x < 0 and y < 0: x' = −y, y' = x, z = −π/2 (0xCDBC0958).
  - Zero detect: if x = y = 0, set out_zero and skip to DONE with angle = 0, mag = 0.
  - Otherwise clear out_zero, set i = 0, go to ITER.
- ITER (exactly ITER cycles), iteration i:
  - y ≥ 0: x += y>>>i; y −= x>>>i; z += atan_tab[i].
  - y < 0: x −= y>>>i; y += x>>>i; z −= atan_tab[i].
  - Arithmetic shifts truncate toward −∞; updates use the pre-iteration x and y simultaneously.
  - atan_tab[i] = round(atan(2^−i)·2^29), constant ROM; atan_tab[0] = 0x1921FB54, atan_tab[1] = 0x0ED63383.
  - After iteration ITER−1: out_angle = z, out_mag = x[30:−1 of Q.30] (internal x >>> 1, low 32 bits), go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0; outputs held stable.
  - On out_ready: out_valid drops at the next edge and state returns to IDLE.
  - A new vector can be accepted the cycle after that; there is no input/output overlap.
- Latency: out_valid rises ITER+2 edges after the accepting edge; 2 edges for a zero vector.
- Throughput: one vector per ITER+3 cycles minimum.
- Boundary conditions:
  - y = 0, x < 0 yields +π (≈ 0x6487ED51), never −π.
  - in_valid while in_ready = 0 is ignored; the source must hold its data.
  - out_ready while out_valid = 0 is ignored.
  - z arithmetic wraps modulo 2^32; it cannot overflow for legal inputs.
- Accuracy for ITER = 16:
  - |angle error| ≤ 2^−13 rad.
  - |mag error| ≤ 2^−12 relative.

Test Plan:
- Reset then (x, y) = (0x40000000, 0) → out_valid 18 cycles after accept; out_angle = 0 ±2^16 LSB; out_mag ≈ 0x34B2xxxx (≈ 884.1e6 ±2^17); out_zero = 0.
- (0, 0x40000000) → out_angle = 0x3243F6A8 ±2^16; (0x40000000, 0x40000000) → out_angle = 0x1921FB54 ±2^16, out_mag ≈ 1.2503e9 ±2^18.
- (0xC0000000, 0) (x = −1.0) → out_angle ≈ +0x6487ED51; (0xC0000000, 0xFFFFFFFF) → out_angle ≈ −π (≈ 0x9B7812AF) ±2^16.
- (0, 0) → out_zero = 1, out_angle = 0, out_mag = 0, out_valid 2 edges after accept.
- Backpressure: hold out_ready = 0 for 10 cycles → outputs and out_valid stable, in_ready = 0, second in_valid ignored; release → one transfer, then IDLE with in_ready = 1.
- reset_n pulsed low mid-ITER → all outputs 0 and in_ready = 1 immediately; next vector (0x40000000, 0x40000000) yields a correct result with no residue.
